// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format encodings for the decode stage.
package riscv_imm_pkg;

    localparam int unsigned IMM_SEL_W = 3;

    localparam logic [IMM_SEL_W-1:0] IMM_I = 3'd0;
    localparam logic [IMM_SEL_W-1:0] IMM_S = 3'd1;
    localparam logic [IMM_SEL_W-1:0] IMM_B = 3'd2;
    localparam logic [IMM_SEL_W-1:0] IMM_U = 3'd3;
    localparam logic [IMM_SEL_W-1:0] IMM_J = 3'd4;
    localparam logic [IMM_SEL_W-1:0] IMM_Z = 3'd5;

endpackage

// File: rtl/immgen_core.sv
// Combinational immediate decoder: instruction bits [31:7] + selector -> XLEN immediate.
module immgen_core
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]          instr,
    input  logic [IMM_SEL_W-1:0] imm_sel,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);

    logic [31:0] imm32;

    // Every format is first built sign-extended to 32 bits; Z is zero-filled so bit 31 stays 0.
    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z:   imm32 = {27'b0, instr[19:15]};
            default: err   = 1'b1;
        endcase
    end

    // Widen from bit 31 so XLEN=64 U-type sign-extends as RV64 requires.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator with a two-entry skid buffer on a valid/ready boundary.
module immgen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [24:0]          in_instr,
    input  logic [IMM_SEL_W-1:0] in_imm_sel,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    // Encoding is {skid valid, out valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]  core_imm;
    logic             core_err;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_out_in;
    logic             load_out_skid;
    logic             load_skid;

    immgen_core #(.XLEN(XLEN)) u_core (
        .instr   (in_instr),
        .imm_sel (in_imm_sel),
        .imm     (core_imm),
        .err     (core_err)
    );

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Next state and register-load steering.
    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_nxt   = ST_ONE;
                    load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_in = 1'b1;
                end else if (in_xfer) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_nxt     = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm  <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_imm <= core_imm;
                out_tag <= in_tag;
                out_err <= core_err;
            end else if (load_out_skid) begin
                out_imm <= skid_imm;
                out_tag <= skid_tag;
                out_err <= skid_err;
            end
            if (load_skid) begin
                skid_imm <= core_imm;
                skid_tag <= in_tag;
                skid_err <= core_err;
            end
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: XLEN=32 and XLEN=64 instances share stimulus, checked against an arithmetic model.
module tb_immgen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] ins;
    logic [2:0]  in_imm_sel;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32, out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    int checks;
    int errors;
    bit rand_mode;
    exp_t q[$];

    immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready32),
        .in_instr   (ins[31:7]),
        .in_imm_sel (in_imm_sel),
        .in_tag     (in_tag),
        .out_valid  (out_valid32),
        .out_ready  (out_ready),
        .out_imm    (out_imm32),
        .out_tag    (out_tag32),
        .out_err    (out_err32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_instr   (ins[31:7]),
        .in_imm_sel (in_imm_sel),
        .in_tag     (in_tag),
        .out_valid  (out_valid64),
        .out_ready  (out_ready),
        .out_imm    (out_imm64),
        .out_tag    (out_tag64),
        .out_err    (out_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sext(input longint v, input int w);
        if (v >= (longint'(1) << (w - 1))) return v - (longint'(1) << w);
        return v;
    endfunction

    // Immediate value computed numerically from the format definitions.
    function automatic logic [63:0] model_imm(input logic [2:0] sel, input logic [31:0] x);
        longint v;
        case (sel)
            3'd0: v = sext(longint'(x[31:20]), 12);
            3'd1: v = sext((longint'(x[31:25]) << 5) + longint'(x[11:7]), 12);
            3'd2: v = sext((longint'(x[31]) << 12) + (longint'(x[7]) << 11)
                           + (longint'(x[30:25]) << 5) + (longint'(x[11:8]) << 1), 13);
            3'd3: v = sext(longint'(x[31:12]) << 12, 32);
            3'd4: v = sext((longint'(x[31]) << 20) + (longint'(x[19:12]) << 12)
                           + (longint'(x[20]) << 11) + (longint'(x[30:21]) << 1), 21);
            3'd5: v = longint'(x[19:15]);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    // Per-cycle compare against the in-flight queue; occupancy also predicts the handshake flags.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
            chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
            chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
            chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
            if (out_valid32 && q.size() > 0) begin
                chk("imm32", 64'(out_imm32), 64'(q[0].imm[31:0]));
                chk("imm64", out_imm64, q[0].imm);
                chk("tag32", 64'(out_tag32), 64'(q[0].tag));
                chk("tag64", 64'(out_tag64), 64'(q[0].tag));
                chk("err32", 64'(out_err32), 64'(q[0].err));
                chk("err64", 64'(out_err64), 64'(q[0].err));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready32) begin
                q.push_back('{imm: model_imm(in_imm_sel, ins), tag: in_tag, err: (in_imm_sel >= 3'd6)});
            end
        end
    end

    // Offer one transaction until accepted; leaves inputs idle at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] sel, input logic [31:0] x, input logic [31:0] tag);
        bit acc;
        acc = 1'b0;
        in_imm_sel = sel;
        ins        = x;
        in_tag     = tag;
        in_valid   = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready32;
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_one(input string name, input logic [2:0] sel, input logic [31:0] x,
                            input logic [31:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                            input logic eerr);
        send(sel, x, tag);
        chk({name, "_valid"}, 64'(out_valid32), 64'(1));
        chk({name, "_imm32"}, 64'(out_imm32), 64'(e32));
        chk({name, "_imm64"}, out_imm64, e64);
        chk({name, "_tag"}, 64'(out_tag32), 64'(tag));
        chk({name, "_err"}, 64'(out_err32), 64'(eerr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rand_mode  = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        ins        = '0;
        in_imm_sel = '0;
        in_tag     = '0;
        out_ready  = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid32), 64'(0));
        chk("rst_in_ready", 64'(in_ready32), 64'(1));
        chk("rst_imm", 64'(out_imm32), 64'(0));
        chk("rst_tag", 64'(out_tag32), 64'(0));
        chk("rst_err", 64'(out_err32), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Hand-computed per-format vectors.
        send_one("I", 3'd0, 32'hFFF0_0000, 32'h11, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send_one("S", 3'd1, 32'h0000_0400, 32'h12, 32'h0000_0008, 64'h0000_0000_0000_0008, 1'b0);
        send_one("B", 3'd2, 32'hFE00_0E80, 32'h13, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        send_one("J", 3'd4, 32'h0010_0000, 32'h14, 32'h0000_0800, 64'h0000_0000_0000_0800, 1'b0);
        send_one("Z", 3'd5, 32'h000F_8000, 32'h15, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0);
        send_one("U_pos", 3'd3, 32'h1234_5000, 32'h16, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
        send_one("U_neg", 3'd3, 32'h8000_0000, 32'h17, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
        send_one("ILL", 3'd6, 32'hDEAD_BEEF, 32'hCAFE, 32'h0, 64'h0, 1'b1);
        send_one("ILL7", 3'd7, 32'hFFFF_FFFF, 32'hBEEF, 32'h0, 64'h0, 1'b1);
        idle(2);

        // Backpressure: tags 1,2 fill OUT and SKID, tag 3 waits upstream.
        out_ready = 1'b0;
        send(3'd0, 32'h0010_0000, 32'd1);
        send(3'd0, 32'h0020_0000, 32'd2);
        in_imm_sel = 3'd0;
        ins        = 32'h0030_0000;
        in_tag     = 32'd3;
        in_valid   = 1'b1;
        idle(2);
        chk("bp_out_tag", 64'(out_tag32), 64'd1);
        chk("bp_in_ready", 64'(in_ready32), 64'd0);
        out_ready = 1'b1;
        idle(1);
        chk("bp_second", 64'(out_tag32), 64'd2);
        idle(1);
        in_valid = 1'b0;
        chk("bp_third", 64'(out_tag32), 64'd3);
        chk("bp_third_valid", 64'(out_valid32), 64'd1);
        idle(1);
        chk("bp_drained", 64'(out_valid32), 64'd0);
        idle(1);

        // Random streaming with random stalls on both sides.
        rand_mode = 1'b1;
        for (int n = 0; n < 100; n++) begin
            send(3'($urandom_range(0, 7)), $urandom, 32'h1000 + 32'(n));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Reset while FULL discards both held entries immediately.
        out_ready = 1'b0;
        send(3'd1, 32'h0000_0080, 32'hAA);
        send(3'd1, 32'h0000_0100, 32'hBB);
        idle(1);
        chk("pre_rst_full", 64'(in_ready32), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid32), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready32), 64'd1);
        chk("mid_rst_tag", 64'(out_tag32), 64'd0);
        chk("mid_rst_imm64", out_imm64, 64'd0);
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send_one("post_rst", 3'd5, 32'h0005_0000, 32'h77, 32'h0000_000A, 64'h0000_0000_0000_000A, 1'b0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Registered, parametrised immediate generator for the decode stage. It takes instruction bits [31:7] plus an immediate selector and produces the sign- or zero-extended immediate at XLEN width. It adds a CSR zero-extended immediate mode and an illegal-selector error flag. A valid/ready interface with a two-entry skid buffer lets the decode→execute boundary stall without bubbles or combinational ready paths.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64
- TAG_W, 32, width of sideband tag carried alongside each immediate (PC, rd, etc.)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has a transaction
- in_ready  output  1  block can accept a transaction; registered
- in_instr  input  25  instruction bits [31:7]
- in_imm_sel  input  3  immediate format selector
- in_tag  input  TAG_W  sideband, passed through unmodified
- out_valid  output  1  out_imm/out_tag/out_err are valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag of the same transaction
- out_err  output  1  selector was illegal for this transaction

## Operation
- Selector encoding (imm = value before extension, instr bit numbering):
  - 000 I: sext(instr[31:20])
  - 001 S: sext({instr[31:25],instr[11:7]})
  - 010 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - 011 U: sext({instr[31:12],12'b0})
  - 100 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 101 Z: zext(instr[19:15])
  - 110, 111: illegal; imm = 0, err = 1
- Sign extension is always from the format's top bit to XLEN. U-type with XLEN=64 sign-extends from bit 31.
- Transfer on input: in_valid && in_ready. Transfer on output: out_valid && out_ready.
- Storage: an output register (OUT) and a skid register (SKID), each holding imm, tag and err. Immediate is computed before capture; there is no decode after registering.
- States, given by {SKID valid, OUT valid}:
  - EMPTY (0,0)
  - ONE (0,1)
  - FULL (1,1)
- Transitions:
  - EMPTY + in transfer → ONE
  - ONE + in transfer, no out transfer → FULL (new data to SKID)
  - ONE + in and out transfer → ONE (new data to OUT)
  - ONE + out only → EMPTY
  - FULL + out transfer → ONE (SKID moves to OUT)
  - in transfer is impossible in FULL
- in_ready = not FULL. It is registered and computed from next state.
- Order is preserved. No transaction is dropped or duplicated.
- Data outputs hold their value while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release): out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_err=0, SKID empty.
- Latency: 1 cycle from input transfer to out_valid when OUT is empty or draining.
- Throughput: 1 transaction per cycle when out_ready is held high.
- No combinational path from out_ready to in_ready, or from inputs to outputs.
- in_ready falls in the cycle after the transfer that fills SKID. It rises in the cycle after OUT drains from FULL.
- Reset mid-operation: all held transactions are discarded and outputs return to reset values immediately.
- in_valid while in_ready=0: the data is ignored; upstream must hold it.

## Structure
- Shared package riscv_imm_pkg holds:
  - localparams IMM_I=3'd0, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z=3'd5
  - IMM_SEL_W=3
- Sub-module immgen_core is the combinational decoder: (instr[31:7], imm_sel) → (imm[XLEN-1:0], err), parametrised on XLEN.
- immgen_pipe contains only the skid/handshake logic around immgen_core.

## Test plan
- Per-format check (XLEN=32, out_ready=1), each → out_valid one cycle later:
  - I, instr[31:20]=12'hFFF → 32'hFFFFFFFF
  - S, instr[31:25]=0, [11:7]=5'b01000 → 32'h00000008
  - B, {instr[31],instr[7],instr[30:25],instr[11:8]}=all ones except instr[8]=0 → 32'hFFFFFFFC
  - J, only instr[20]=1 → 32'h00000800
  - Z, instr[19:15]=5'h1F → 32'h0000001F
- XLEN=64 U-type: instr[31:12]=20'h12345 → 64'h0000000012345000; instr[31:12]=20'h80000 → 64'hFFFFFFFF80000000.
- Illegal selector: imm_sel=3'b110 with arbitrary instr, tag=32'hCAFE → out_imm=0, out_err=1, out_tag=32'hCAFE.
- Backpressure:
  - Stimulus: out_ready=0; offer tags 1,2,3 on consecutive cycles.
  - Response: tag 1 in OUT, tag 2 in SKID, in_ready=0, tag 3 held upstream.
  - Then raise out_ready: outputs 1,2,3 in order on consecutive cycles, no duplicates.
- Streaming: 100 random transactions with random in_valid/out_ready → scoreboard matches a reference model exactly, in order.
- Reset in FULL state: assert rst_n=0 → out_valid=0, in_ready=1 immediately. After release, the first new transaction appears with 1-cycle latency and no stale data.
